pwd_entry: RTL and testbench

Input front-end for the combination lock. It conditions the four raw digit toggle switches: each key is synchronized, debounced and rising-edge detected, and drives a mod-10 digit register. The block replaces direct switch-clocked counters with a single-clock design. It also offers a snapshot/commit handshake so the lock core can take a stable 4-digit code.

---
 rtl/pwd_entry_pkg.sv | 20 ++
 rtl/pwd_entry_if.sv | 29 ++
 rtl/pwd_entry_key_debounce.sv | 83 ++++++++
 rtl/pwd_entry.sv | 82 ++++++++
 tb/tb_pwd_entry.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwd_entry_pkg.sv
// Shared constants, debounce state type and BCD helper for the lock input front-end.
package lock_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        LOW_CHK  = 2'd1,
        HIGH     = 2'd2,
        HIGH_CHK = 2'd3
    } db_state_t;

    // Anything at or above 9 wraps to 0, which also scrubs illegal codes 10-15.
    function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] d);
        return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/pwd_entry_if.sv
// Signal bundle between the lock core (master) and the pwd_entry front-end (slave).
interface pwd_entry_if;
    import lock_pkg::*;

    logic [NUM_DIGITS-1:0]         key;
    logic                          enable;
    logic                          clear;
    logic                          commit;
    logic                          code_ack;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits;
    logic [NUM_DIGITS-1:0]         inc_pulse;
    // Snapshot handshake: code is stable while code_valid is high; a cycle with
    // code_ack high consumes it, and commit with code_ack in that same cycle
    // replaces it immediately. commit while valid and not acked is dropped.
    logic [NUM_DIGITS*DIGIT_W-1:0] code;
    logic                          code_valid;
    db_state_t [NUM_DIGITS-1:0]    db_state;

    modport master (
        output key, enable, clear, commit, code_ack,
        input  digits, inc_pulse, code, code_valid, db_state
    );

    modport slave (
        input  key, enable, clear, commit, code_ack,
        output digits, inc_pulse, code, code_valid, db_state
    );

endinterface

// File: rtl/pwd_entry_key_debounce.sv
// Two-flop synchronizer plus stable-level debouncer for one raw switch; pulses rise_o once per accepted press.
module key_debounce
    import lock_pkg::*;
#(
    parameter int DB_CYCLES = 2000000,
    parameter int DB_W      = 21
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      key_i,
    output logic      rise_o,
    output db_state_t state_o
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1);

    logic [1:0]      sync_q;
    db_state_t       state_q;
    logic [DB_W-1:0] cnt_q;
    logic            rise_q;
    logic            ks;

    assign ks      = sync_q[1];
    assign rise_o  = rise_q;
    assign state_o = state_q;

    // Entering a CHK state counts the first stable sample, so the level must hold
    // for exactly DB_CYCLES consecutive samples before it is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b00;
            state_q <= LOW;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], key_i};
            rise_q <= 1'b0;
            case (state_q)
                LOW: begin
                    if (ks) begin
                        state_q <= LOW_CHK;
                        cnt_q   <= CNT_ONE;
                    end
                end
                LOW_CHK: begin
                    if (!ks) begin
                        state_q <= LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= HIGH;
                        cnt_q   <= '0;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!ks) begin
                        state_q <= HIGH_CHK;
                        cnt_q   <= CNT_ONE;
                    end
                end
                HIGH_CHK: begin
                    if (ks) begin
                        state_q <= HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= LOW;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= LOW;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pwd_entry.sv
// Combination-lock input front-end: four debounced keys drive BCD digit registers,
// with a commit/ack snapshot of the 4-digit code for the lock core.
module pwd_entry
    import lock_pkg::*;
#(
    parameter int DB_CYCLES = 2000000,
    parameter int DB_W      = 21
) (
    input logic        clk,
    input logic        reset,
    pwd_entry_if.slave bus
);

    logic [NUM_DIGITS-1:0]              rise;
    db_state_t [NUM_DIGITS-1:0]         db_state;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]              inc_pulse_q, inc_pulse_d;
    logic [NUM_DIGITS*DIGIT_W-1:0]      code_q, code_d;
    logic                               code_valid_q, code_valid_d;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_key
        key_debounce #(
            .DB_CYCLES(DB_CYCLES),
            .DB_W     (DB_W)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .key_i  (bus.key[i]),
            .rise_o (rise[i]),
            .state_o(db_state[i])
        );
    end

    // A rise arriving while disabled is simply dropped; the debouncer already sits
    // in HIGH, so raising enable later cannot replay it.
    always_comb begin
        digits_d    = digits_q;
        inc_pulse_d = '0;
        if (bus.clear) begin
            digits_d = '0;
        end else if (bus.enable) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (rise[i]) begin
                    digits_d[i]    = bcd_inc(digits_q[i]);
                    inc_pulse_d[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        code_d       = code_q;
        code_valid_d = code_valid_q;
        if (bus.commit && (!code_valid_q || bus.code_ack)) begin
            code_d       = digits_q;
            code_valid_d = 1'b1;
        end else if (bus.code_ack) begin
            code_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digits_q     <= '0;
            inc_pulse_q  <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
        end else begin
            digits_q     <= digits_d;
            inc_pulse_q  <= inc_pulse_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
        end
    end

    assign bus.digits     = digits_q;
    assign bus.inc_pulse  = inc_pulse_q;
    assign bus.code       = code_q;
    assign bus.code_valid = code_valid_q;
    assign bus.db_state   = db_state;

endmodule

// File: tb/tb_pwd_entry.sv
// Directed bench for pwd_entry with a short debounce window: timing sequences plus a press/handshake table.
module tb_pwd_entry;
    import lock_pkg::*;

    localparam int DB  = 4;
    localparam int DBW = 3;
    localparam int LAT = DB + 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pwd_entry_if bus ();

    pwd_entry #(
        .DB_CYCLES(DB),
        .DB_W     (DBW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    int pulse_tot[NUM_DIGITS];

    always @(negedge clk) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bus.inc_pulse[i]) pulse_tot[i]++;
        end
    end

    typedef struct {
        logic [3:0]  mask;
        logic        en;
        logic        commit;
        logic        ack;
        logic [15:0] exp_digits;
        logic [15:0] exp_code;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] m, input logic en, input logic cm, input logic ak,
                                input logic [15:0] d, input logic [15:0] c, input logic v);
        vec_t r;
        r.mask = m; r.en = en; r.commit = cm; r.ack = ak;
        r.exp_digits = d; r.exp_code = c; r.exp_valid = v;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] mask);
        bus.key = bus.key | mask;
        repeat (LAT + 3) step();
        bus.key = bus.key & ~mask;
        repeat (LAT + 2) step();
    endtask

    task automatic apply(input vec_t v, input int idx);
        int base[NUM_DIGITS];
        for (int i = 0; i < NUM_DIGITS; i++) base[i] = pulse_tot[i];
        bus.enable = v.en;
        if (v.mask != 4'b0000) press(v.mask);
        bus.commit   = v.commit;
        bus.code_ack = v.ack;
        step();
        bus.commit   = 1'b0;
        bus.code_ack = 1'b0;
        check($sformatf("row%0d_digits", idx), 32'(bus.digits), 32'(v.exp_digits));
        check($sformatf("row%0d_code", idx), 32'(bus.code), 32'(v.exp_code));
        check($sformatf("row%0d_valid", idx), 32'(bus.code_valid), 32'(v.exp_valid));
        for (int i = 0; i < NUM_DIGITS; i++) begin
            check($sformatf("row%0d_pulses%0d", idx, i), 32'(pulse_tot[i] - base[i]),
                  32'((v.mask[i] && v.en) ? 1 : 0));
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base1;
        int base0;

        // Table: presses and handshake steps, starting from digits 16'h0101.
        vecs.push_back(mk(4'b1000, 1, 0, 0, 16'h1101, 16'h0000, 0));
        vecs.push_back(mk(4'b1000, 1, 0, 0, 16'h2101, 16'h0000, 0));
        vecs.push_back(mk(4'b1000, 1, 0, 0, 16'h3101, 16'h0000, 0));
        vecs.push_back(mk(4'b1000, 1, 0, 0, 16'h4101, 16'h0000, 0));
        vecs.push_back(mk(4'b1000, 1, 0, 0, 16'h5101, 16'h0000, 0));
        vecs.push_back(mk(4'b1000, 1, 0, 0, 16'h6101, 16'h0000, 0));
        vecs.push_back(mk(4'b1000, 1, 0, 0, 16'h7101, 16'h0000, 0));
        vecs.push_back(mk(4'b1000, 1, 0, 0, 16'h8101, 16'h0000, 0));
        vecs.push_back(mk(4'b1000, 1, 0, 0, 16'h9101, 16'h0000, 0));
        vecs.push_back(mk(4'b1000, 1, 0, 0, 16'h0101, 16'h0000, 0));
        vecs.push_back(mk(4'b0110, 1, 0, 0, 16'h0211, 16'h0000, 0));
        vecs.push_back(mk(4'b0110, 1, 0, 0, 16'h0321, 16'h0000, 0));
        vecs.push_back(mk(4'b1000, 1, 0, 0, 16'h1321, 16'h0000, 0));
        vecs.push_back(mk(4'b1000, 1, 0, 0, 16'h2321, 16'h0000, 0));
        vecs.push_back(mk(4'b1000, 1, 0, 0, 16'h3321, 16'h0000, 0));
        vecs.push_back(mk(4'b1000, 1, 0, 0, 16'h4321, 16'h0000, 0));
        vecs.push_back(mk(4'b0000, 1, 1, 0, 16'h4321, 16'h4321, 1));
        vecs.push_back(mk(4'b0001, 1, 1, 0, 16'h4322, 16'h4321, 1));
        vecs.push_back(mk(4'b0000, 1, 1, 1, 16'h4322, 16'h4322, 1));
        vecs.push_back(mk(4'b1000, 1, 1, 1, 16'h5322, 16'h5322, 1));
        vecs.push_back(mk(4'b0000, 1, 0, 1, 16'h5322, 16'h5322, 0));
        vecs.push_back(mk(4'b0000, 1, 0, 1, 16'h5322, 16'h5322, 0));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 16'h5322, 16'h5322, 0));
        vecs.push_back(mk(4'b0000, 1, 1, 0, 16'h5322, 16'h5322, 1));
        vecs.push_back(mk(4'b0000, 1, 0, 1, 16'h5322, 16'h5322, 0));

        reset        = 1'b0;
        bus.key      = '0;
        bus.enable   = 1'b0;
        bus.clear    = 1'b0;
        bus.commit   = 1'b0;
        bus.code_ack = 1'b0;
        repeat (3) step();

        check("rst_digits", 32'(bus.digits), 32'h0);
        check("rst_pulse", 32'(bus.inc_pulse), 32'h0);
        check("rst_code", 32'(bus.code), 32'h0);
        check("rst_valid", 32'(bus.code_valid), 32'h0);
        check("rst_state", 32'(bus.db_state), 32'h0);

        reset      = 1'b1;
        bus.enable = 1'b1;
        repeat (2) step();

        // Clean press on key 0: pulse and digit both land LAT edges after the key edge.
        step();
        bus.key[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("t1_pulse_e%0d", k), 32'(bus.inc_pulse), 32'((k == LAT) ? 4'b0001 : 4'b0000));
            check($sformatf("t1_digits_e%0d", k), 32'(bus.digits), 32'((k >= LAT) ? 16'h0001 : 16'h0000));
            if (k == 3) check("t1_state_lowchk", 32'(bus.db_state[0]), 32'(LOW_CHK));
        end
        bus.key[0] = 1'b0;
        repeat (LAT + 2) step();

        // Bounce on key 2: high 3, low 1, then steady; timing restarts from the last rise.
        step();
        bus.key[2] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            check($sformatf("t2_pulse_e%0d", k), 32'(bus.inc_pulse), 32'((k == LAT + 4) ? 4'b0100 : 4'b0000));
            check($sformatf("t2_digits_e%0d", k), 32'(bus.digits), 32'((k >= LAT + 4) ? 16'h0101 : 16'h0001));
            if (k == 3) bus.key[2] = 1'b0;
            if (k == 4) bus.key[2] = 1'b1;
        end
        bus.key[2] = 1'b0;
        repeat (LAT + 2) step();

        for (int r = 0; r < vecs.size(); r++) apply(vecs[r], r);

        // Commit in the same cycle as an increment captures the pre-update digits.
        step();
        bus.key[1] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == LAT) begin
                bus.commit = 1'b0;
                check("cmt_inc_digits", 32'(bus.digits), 32'h5332);
                check("cmt_inc_code", 32'(bus.code), 32'h5322);
                check("cmt_inc_valid", 32'(bus.code_valid), 32'h1);
            end
            if (k == LAT - 1) bus.commit = 1'b1;
        end
        bus.key[1] = 1'b0;
        bus.code_ack = 1'b1;
        step();
        bus.code_ack = 1'b0;
        check("cmt_inc_ack", 32'(bus.code_valid), 32'h0);
        repeat (LAT + 2) step();

        // Clear in the cycle the key 1 rise arrives: digits zero, no pulse.
        base1 = pulse_tot[1];
        step();
        bus.key[1] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == LAT) begin
                bus.clear = 1'b0;
                check("clr_digits", 32'(bus.digits), 32'h0);
                check("clr_pulse", 32'(bus.inc_pulse), 32'h0);
            end
            if (k == LAT - 1) begin
                check("clr_state_high", 32'(bus.db_state[1]), 32'(HIGH));
                bus.clear = 1'b1;
            end
        end
        bus.key[1] = 1'b0;
        repeat (LAT + 2) step();
        check("clr_no_pulse", 32'(pulse_tot[1] - base1), 32'h0);

        // Press while disabled, then enable with the key still held.
        base0 = pulse_tot[0];
        bus.enable = 1'b0;
        step();
        bus.key[0] = 1'b1;
        repeat (10) step();
        check("dis_digits", 32'(bus.digits), 32'h0);
        bus.enable = 1'b1;
        repeat (5) step();
        check("reen_digits", 32'(bus.digits), 32'h0);
        bus.key[0] = 1'b0;
        repeat (LAT + 2) step();
        check("reen_no_pulse", 32'(pulse_tot[0] - base0), 32'h0);

        // Reset mid-debounce with digits 0905 and a pending snapshot.
        repeat (5) press(4'b0101);
        repeat (4) press(4'b0100);
        check("pre_rst_digits", 32'(bus.digits), 32'h0905);
        bus.commit = 1'b1;
        step();
        bus.commit = 1'b0;
        check("pre_rst_code", 32'(bus.code), 32'h0905);
        bus.key[0] = 1'b1;
        repeat (4) step();
        check("pre_rst_state", 32'(bus.db_state[0]), 32'(LOW_CHK));
        reset = 1'b0;
        #1;
        check("mid_rst_digits", 32'(bus.digits), 32'h0);
        check("mid_rst_code", 32'(bus.code), 32'h0);
        check("mid_rst_valid", 32'(bus.code_valid), 32'h0);
        check("mid_rst_state", 32'(bus.db_state), 32'h0);
        repeat (2) step();
        reset = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("t6_pulse_e%0d", k), 32'(bus.inc_pulse), 32'((k == LAT) ? 4'b0001 : 4'b0000));
            check($sformatf("t6_digits_e%0d", k), 32'(bus.digits), 32'((k >= LAT) ? 16'h0001 : 16'h0000));
        end
        bus.key[0] = 1'b0;
        repeat (LAT + 2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
